pic_bus_master: RTL and testbench

Host-side bus initiator for the 8259A core. It drives the chip_select_n / read_enable_n / write_enable_n / address / data bus pins that the PIC read/write block decodes. It converts valid/ready command requests into timed 8080-style read and write cycles. It also contains an autonomous ICW1..ICW4 initialisation sequencer, so benches and SoC wrappers can program the PIC without hand-timed strobes.

---
 rtl/pic_bus_pkg.sv | 32 +++
 rtl/pic_bus_master_if.sv | 22 ++
 rtl/pic_bus_cycle.sv | 103 ++++++++++
 rtl/pic_bus_master.sv | 117 +++++++++++
 tb/tb_pic_bus_master.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/pic_bus_pkg.sv
// rtl/pic_bus_pkg.sv - shared states, ICW1 bit positions and sequencer step helper
package pic_bus_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} cycle_state_t;
    typedef enum logic [2:0] {SEQ_IDLE, SEQ_ICW1, SEQ_ICW2, SEQ_ICW3, SEQ_ICW4} seq_state_t;

    localparam int ICW1_IC4_BIT  = 0;
    localparam int ICW1_SNGL_BIT = 1;
    localparam int ICW1_INIT_BIT = 4;

    // ICW3 only in cascade mode (SNGL=0); ICW4 only when ICW1 asks for it (IC4=1).
    function automatic seq_state_t seq_next(seq_state_t cur, logic [7:0] icw1_word);
        seq_state_t nxt;
        nxt = SEQ_IDLE;
        case (cur)
            SEQ_ICW1: nxt = SEQ_ICW2;
            SEQ_ICW2: begin
                if (!icw1_word[ICW1_SNGL_BIT])
                    nxt = SEQ_ICW3;
                else if (icw1_word[ICW1_IC4_BIT])
                    nxt = SEQ_ICW4;
            end
            SEQ_ICW3: begin
                if (icw1_word[ICW1_IC4_BIT])
                    nxt = SEQ_ICW4;
            end
            default: nxt = SEQ_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pic_bus_master_if.sv
// rtl/pic_bus_master_if.sv - 8080-style pin bus between host master and PIC
interface pic_bus_master_if;
    logic       chip_select_n;
    logic       read_enable_n;
    logic       write_enable_n;
    logic       address;
    logic [7:0] data_bus_out;
    logic       data_bus_oe;
    logic [7:0] data_bus_in;

    modport master (
        output chip_select_n, read_enable_n, write_enable_n, address,
               data_bus_out, data_bus_oe,
        input  data_bus_in
    );

    modport slave (
        input  chip_select_n, read_enable_n, write_enable_n, address,
               data_bus_out, data_bus_oe,
        output data_bus_in
    );
endinterface

// File: rtl/pic_bus_cycle.sv
// rtl/pic_bus_cycle.sv - timed SETUP/STROBE/HOLD/RECOVER cycle engine with registered pins
module pic_bus_cycle
    import pic_bus_pkg::*;
#(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1,
    parameter int RECOVERY_CYCLES = 1,
    parameter int CNT_W           = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       write,
    input  logic       addr,
    input  logic [7:0] wdata,
    output logic       idle,
    output logic       done,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    pic_bus_master_if.master bus
);

    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'((RECOVERY_CYCLES > 0) ? RECOVERY_CYCLES - 1 : 0);

    cycle_state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, phase_last;
    logic             last, wr_q, req_wr, in_cycle_n, read_sample;

    assign idle = (state == IDLE);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + 1'b1;
        phase_last = '0;
        case (state)
            SETUP:   phase_last = SETUP_LAST;
            STROBE:  phase_last = STROBE_LAST;
            HOLD:    phase_last = HOLD_LAST;
            RECOVER: phase_last = RECOVER_LAST;
            default: phase_last = '0;
        endcase
        last = (cnt == phase_last);
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start)
                    state_n = SETUP;
            end
            SETUP:   if (last) begin state_n = STROBE; cnt_n = '0; end
            STROBE:  if (last) begin state_n = HOLD;   cnt_n = '0; end
            HOLD: begin
                if (last) begin
                    state_n = (RECOVERY_CYCLES == 0) ? IDLE : RECOVER;
                    cnt_n   = '0;
                end
            end
            RECOVER: if (last) begin state_n = IDLE; cnt_n = '0; end
            default: begin state_n = IDLE; cnt_n = '0; end
        endcase
        // The request is only latched on the IDLE->SETUP edge, so use the live input then.
        req_wr      = (state == IDLE) ? write : wr_q;
        in_cycle_n  = (state_n == SETUP) || (state_n == STROBE) || (state_n == HOLD);
        read_sample = (state == STROBE) && last && !wr_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            wr_q               <= 1'b0;
            done               <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_data           <= 8'h00;
            bus.chip_select_n  <= 1'b1;
            bus.read_enable_n  <= 1'b1;
            bus.write_enable_n <= 1'b1;
            bus.address        <= 1'b0;
            bus.data_bus_out   <= 8'h00;
            bus.data_bus_oe    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            done  <= (state != IDLE) && (state_n == IDLE);
            if (state == IDLE && start) begin
                wr_q             <= write;
                bus.address      <= addr;
                bus.data_bus_out <= wdata;
            end
            bus.chip_select_n  <= !in_cycle_n;
            bus.write_enable_n <= !((state_n == STROBE) && req_wr);
            bus.read_enable_n  <= !((state_n == STROBE) && !req_wr);
            bus.data_bus_oe    <= in_cycle_n && req_wr;
            rsp_valid          <= read_sample;
            if (read_sample)
                rsp_data <= bus.data_bus_in;
        end
    end

endmodule

// File: rtl/pic_bus_master.sv
// rtl/pic_bus_master.sv - host command arbitration plus ICW1..ICW4 init sequencer
module pic_bus_master
    import pic_bus_pkg::*;
#(
    parameter int SETUP_CYCLES    = 1,
    parameter int STROBE_CYCLES   = 2,
    parameter int HOLD_CYCLES     = 1,
    parameter int RECOVERY_CYCLES = 1,
    parameter int CNT_W           = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_address,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       init_start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    output logic       init_busy,
    output logic       init_done,
    pic_bus_master_if.master bus
);

    seq_state_t seq, seq_n;
    logic [7:0] w1, w2, w3, w4, seq_word, req_data;
    logic       pending, cyc_idle, cyc_done;
    logic       seq_issue, host_accept, seq_launch, seq_step;
    logic       req_start, req_write, req_addr;

    assign cmd_ready   = cyc_idle && !init_busy && !init_start;
    assign host_accept = cmd_valid && cmd_ready;
    // Sequencer waits for the engine to be idle, which also queues an init behind a host cycle.
    assign seq_issue   = (seq != SEQ_IDLE) && !pending && cyc_idle;
    assign seq_launch  = init_start && !init_busy;
    assign seq_step    = cyc_done && pending;

    always_comb begin
        seq_n = seq;
        if (seq_launch)
            seq_n = SEQ_ICW1;
        else if (seq_step)
            seq_n = seq_next(seq, w1);

        case (seq)
            SEQ_ICW1: seq_word = w1;
            SEQ_ICW2: seq_word = w2;
            SEQ_ICW3: seq_word = w3;
            SEQ_ICW4: seq_word = w4;
            default:  seq_word = 8'h00;
        endcase

        req_start = seq_issue || host_accept;
        req_write = seq_issue ? 1'b1 : cmd_write;
        req_addr  = seq_issue ? (seq != SEQ_ICW1) : cmd_address;
        req_data  = seq_issue ? seq_word : cmd_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq       <= SEQ_IDLE;
            pending   <= 1'b0;
            init_busy <= 1'b0;
            init_done <= 1'b0;
            w1        <= 8'h00;
            w2        <= 8'h00;
            w3        <= 8'h00;
            w4        <= 8'h00;
        end else begin
            seq <= seq_n;
            if (seq_launch) begin
                w1                <= icw1;
                w1[ICW1_INIT_BIT] <= 1'b1;
                w2                <= icw2;
                w3                <= icw3;
                w4                <= icw4;
                init_busy         <= 1'b1;
                init_done         <= 1'b0;
                pending           <= 1'b0;
            end else if (seq_issue) begin
                pending <= 1'b1;
            end else if (seq_step) begin
                pending <= 1'b0;
                if (seq_n == SEQ_IDLE) begin
                    init_busy <= 1'b0;
                    init_done <= 1'b1;
                end
            end
        end
    end

    pic_bus_cycle #(
        .SETUP_CYCLES   (SETUP_CYCLES),
        .STROBE_CYCLES  (STROBE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .RECOVERY_CYCLES(RECOVERY_CYCLES),
        .CNT_W          (CNT_W)
    ) u_cycle (
        .clock    (clock),
        .reset    (reset),
        .start    (req_start),
        .write    (req_write),
        .addr     (req_addr),
        .wdata    (req_data),
        .idle     (cyc_idle),
        .done     (cyc_done),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .bus      (bus)
    );

endmodule

// File: tb/tb_pic_bus_master.sv
// tb/tb_pic_bus_master.sv - scoreboard bench for pic_bus_master with directed vectors
module tb_pic_bus_master;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0, cmd_write = 1'b0, cmd_address = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, rsp_valid, init_busy, init_done;
    logic [7:0] rsp_data;
    logic       init_start = 1'b0;
    logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00;
    logic [7:0] pic_rd_data = 8'h00;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    logic prev_wr = 1'b1;

    logic [8:0] exp_wr[$];
    logic [7:0] exp_rsp[$];

    pic_bus_master_if bus();
    assign bus.data_bus_in = bus.read_enable_n ? 8'hFF : pic_rd_data;

    pic_bus_master dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .init_start(init_start), .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
        .init_busy(init_busy), .init_done(init_done),
        .bus(bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: every write strobe start and every rsp_valid pops an expectation.
    always @(negedge clock) begin
        logic [8:0] ew;
        logic [7:0] er;
        if (!reset) begin
            if (prev_wr && !bus.write_enable_n) begin
                wr_count++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: got a0=%0d data=%02h expected none", bus.address, bus.data_bus_out);
                end else begin
                    ew = exp_wr.pop_front();
                    if ({bus.address, bus.data_bus_out, bus.data_bus_oe, bus.chip_select_n} !== {ew, 1'b1, 1'b0}) begin
                        errors++;
                        $display("FAIL wr_cycle: got a0=%0d data=%02h oe=%0d cs_n=%0d expected a0=%0d data=%02h oe=1 cs_n=0",
                                 bus.address, bus.data_bus_out, bus.data_bus_oe, bus.chip_select_n, ew[8], ew[7:0]);
                    end
                end
            end
            if (rsp_valid) begin
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected: got %02h expected none", rsp_data);
                end else begin
                    er = exp_rsp.pop_front();
                    if (rsp_data !== er) begin
                        errors++;
                        $display("FAIL rsp_data: got %02h expected %02h", rsp_data, er);
                    end
                end
            end
            if (!bus.read_enable_n && !bus.write_enable_n) begin
                errors++;
                $display("FAIL both_strobes: got rd_n=0 wr_n=0 expected at most one low");
            end
        end
        prev_wr = bus.write_enable_n;
    end

    initial begin
        logic [6:1] cs_v, wr_v, rd_v, oe_v, rdy_v, rv_v;
        int n, wr_before;
        logic busy_prev, ready_seen, done_at_accept;

        // Reset state
        #12;
        chk("reset_state",
            {bus.chip_select_n, bus.read_enable_n, bus.write_enable_n, bus.address,
             bus.data_bus_out, bus.data_bus_oe, rsp_valid, rsp_data, init_busy, init_done},
            {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Write A0=1 0x20
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 1'b1; cmd_data = 8'h20;
        exp_wr.push_back({1'b1, 8'h20});
        @(negedge clock);
        chk("t1_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            cs_v[k] = bus.chip_select_n; wr_v[k] = bus.write_enable_n;
            oe_v[k] = bus.data_bus_oe;   rdy_v[k] = cmd_ready;
        end
        chk("t1_cs_n", cs_v, 6'b110000);
        chk("t1_wr_n", wr_v, 6'b111001);
        chk("t1_oe", oe_v, 6'b001111);
        chk("t1_ready", rdy_v, 6'b100000);

        // Read A0=0, PIC returns 0xA5 during strobe
        tick();
        pic_rd_data = 8'hA5;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 1'b0; cmd_data = 8'h00;
        exp_rsp.push_back(8'hA5);
        tick();
        cmd_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            rd_v[k] = bus.read_enable_n; wr_v[k] = bus.write_enable_n;
            rv_v[k] = rsp_valid;         oe_v[k] = bus.data_bus_oe;
            if (k == 4) chk("t2_rsp_data", rsp_data, 8'hA5);
            if (k == 2) chk("t2_address", bus.address, 0);
        end
        chk("t2_rd_n", rd_v, 6'b111001);
        chk("t2_wr_n", wr_v, 6'b111111);
        chk("t2_rsp_valid", rv_v, 6'b001000);
        chk("t2_oe", oe_v, 6'b000000);

        // Init, single mode, no ICW4: two words
        tick();
        wr_before = wr_count;
        icw1 = 8'h02; icw2 = 8'h08; icw3 = 8'h99; icw4 = 8'h99;
        exp_wr.push_back({1'b0, 8'h12});
        exp_wr.push_back({1'b1, 8'h08});
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        n = 0;
        while (!init_done && n < 300) begin @(negedge clock); n++; end
        chk("t3_timeout", (n < 300), 1);
        @(negedge clock);
        chk("t3_writes", wr_count - wr_before, 2);
        chk("t3_busy_done", {init_busy, init_done}, 2'b01);

        // Init, cascade with ICW4: four words
        tick();
        wr_before = wr_count;
        icw1 = 8'h11; icw2 = 8'h20; icw3 = 8'h04; icw4 = 8'h01;
        exp_wr.push_back({1'b0, 8'h11});
        exp_wr.push_back({1'b1, 8'h20});
        exp_wr.push_back({1'b1, 8'h04});
        exp_wr.push_back({1'b1, 8'h01});
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        n = 0; ready_seen = 1'b0; busy_prev = 1'b1;
        @(negedge clock);
        chk("t4_busy_start", {init_busy, init_done}, 2'b10);
        while (!init_done && n < 300) begin
            if (cmd_ready) ready_seen = 1'b1;
            busy_prev = init_busy;
            @(negedge clock);
            n++;
        end
        chk("t4_timeout", (n < 300), 1);
        chk("t4_ready_low", ready_seen, 0);
        chk("t4_busy_edge", {busy_prev, init_busy}, 2'b10);
        chk("t4_writes", wr_count - wr_before, 4);

        // Reset during STROBE of a write
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 1'b0; cmd_data = 8'h55;
        exp_wr.push_back({1'b0, 8'h55});
        tick();
        cmd_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("t5_in_strobe", bus.write_enable_n, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_drop", {bus.write_enable_n, bus.chip_select_n, bus.data_bus_oe}, 3'b110);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("t5_after_reset", {cmd_ready, init_done, init_busy}, 3'b100);

        // init_start and cmd_valid together: init wins, host write waits for init_done
        tick();
        icw1 = 8'h03; icw2 = 8'h40; icw3 = 8'hEE; icw4 = 8'h02;
        exp_wr.push_back({1'b0, 8'h13});
        exp_wr.push_back({1'b1, 8'h40});
        exp_wr.push_back({1'b1, 8'h02});
        exp_wr.push_back({1'b1, 8'h77});
        init_start = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 1'b1; cmd_data = 8'h77;
        @(negedge clock);
        chk("t6_ready_blocked", cmd_ready, 0);
        tick();
        init_start = 1'b0;
        n = 0; done_at_accept = 1'b0;
        @(negedge clock);
        while (!cmd_ready && n < 300) begin @(negedge clock); n++; end
        done_at_accept = init_done;
        chk("t6_timeout", (n < 300), 1);
        tick();
        cmd_valid = 1'b0;
        chk("t6_done_at_accept", done_at_accept, 1);
        repeat (10) @(negedge clock);
        chk("t_end_wr_queue", exp_wr.size(), 0);
        chk("t_end_rsp_queue", exp_rsp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
